// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot (or one-cold) decoder with a direct-select
// mode and an auto-scan mode that dwells DWELL cycles on each index.
module decoder_scan #(
   parameter int SEL_W      = 3,
   parameter int DWELL      = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [2**SEL_W-1:0]   out,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int N     = 2**SEL_W;
   localparam int CNT_W = $clog2(DWELL + 1);
   // Terminal dwell count; reaching it advances the scan index.
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(DWELL - 1);
   localparam logic [N-1:0]     INACTIVE = {N{(ACTIVE_LOW != 0)}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [SEL_W-1:0]  idx_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              wrap_nx;
   logic [N-1:0]      out_nx;

   // One-hot decode of an index, inverted for one-cold outputs.
   function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
      logic [N-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      if (ACTIVE_LOW != 0) r = ~r;
      return r;
   endfunction

   // Next-state, index, dwell counter and wrap pulse; out follows the next index.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = '0;
      wrap_nx  = 1'b0;
      if (!en) begin
         state_nx = IDLE;
      end else if (!mode) begin
         state_nx = DIRECT;
         idx_nx   = sel;
      end else if (state != SCAN) begin
         // Scan entry (from IDLE or DIRECT) always restarts from sel.
         state_nx = SCAN;
         idx_nx   = sel;
      end else if (cnt == LAST) begin
         idx_nx  = idx + 1'b1;
         wrap_nx = (idx == '1);
      end else begin
         cnt_nx = cnt + 1'b1;
      end
      out_nx = (state_nx == IDLE) ? INACTIVE : decode(idx_nx);
   end

   // State and output registers; reset clears all scan progress immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         wrap  <= 1'b0;
         out   <= INACTIVE;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         wrap  <= wrap_nx;
         out   <= out_nx;
      end
   end

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed scenarios plus randomized stimulus against a
// cycle-count based reference model of the decoder/scanner.
module tb_decoder_scan;

   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en = 1'b0, mode = 1'b0;
   logic [2:0] sel = '0;
   logic [7:0] out;
   logic [2:0] idx;
   logic       wrap;

   logic       en2 = 1'b0, mode2 = 1'b0;
   logic [1:0] sel2 = '0;
   logic [3:0] out2;
   logic [1:0] idx2;
   logic       wrap2;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: index derived from scan start and elapsed cycles.
   int m_idx = 0, m_start = 0, m_t = 0;
   bit m_active = 0, m_scan = 0, m_wrap = 0;

   decoder_scan #(.SEL_W(3), .DWELL(DW), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .out(out), .idx(idx), .wrap(wrap)
   );

   decoder_scan #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2),
      .out(out2), .idx(idx2), .wrap(wrap2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_idx = 0; m_active = 0; m_scan = 0; m_wrap = 0; m_t = 0; m_start = 0;
   endtask

   task automatic model_update(input logic e, input logic m, input logic [2:0] s);
      if (!e) begin
         m_active = 0; m_scan = 0; m_wrap = 0;
      end else if (!m) begin
         m_active = 1; m_scan = 0; m_idx = s; m_wrap = 0;
      end else if (!m_scan) begin
         m_active = 1; m_scan = 1; m_start = s; m_t = 0; m_idx = s; m_wrap = 0;
      end else begin
         m_t++;
         m_idx  = (m_start + m_t / DW) % 8;
         m_wrap = (m_t % DW == 0) && (m_idx == 0);
      end
   endtask

   function automatic logic [7:0] exp_out();
      return m_active ? (8'b1 << m_idx) : 8'h00;
   endfunction

   // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
   task automatic step(input logic e, input logic m, input logic [2:0] s);
      en = e; mode = m; sel = s;
      @(posedge clk);
      model_update(e, m, s);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (out !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: out=%h idx=%0d wrap=%b required out=00 idx=0 wrap=0", out, idx, wrap);
      end
      tests_run++;
      if (out2 !== 4'hF || idx2 !== 2'd0 || wrap2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state_al: out=%h idx=%0d wrap=%b required out=f idx=0 wrap=0", out2, idx2, wrap2);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_direct();
      step(1, 0, 5);
      tests_run++;
      if (out !== 8'b0010_0000 || idx !== 3'd5) begin
         tests_failed++;
         $display("FAIL direct_sel5: out=%b idx=%0d required out=00100000 idx=5", out, idx);
      end
      step(1, 0, 2);
      tests_run++;
      if (out !== 8'b0000_0100 || idx !== 3'd2 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL direct_sel2: out=%b idx=%0d wrap=%b required out=00000100 idx=2 wrap=0", out, idx, wrap);
      end
   endtask

   task automatic test_scan_wrap();
      int ei;
      for (int i = 0; i <= 12; i++) begin
         // sel is random after entry and must be ignored.
         if (i == 0) step(1, 1, 6);
         else step(1, 1, 3'($urandom_range(0, 7)));
         ei = (i < 4) ? 6 : (i < 8) ? 7 : (i < 12) ? 0 : 1;
         tests_run++;
         if (idx !== 3'(ei) || wrap !== (i == 8) || out !== (8'b1 << ei)) begin
            tests_failed++;
            $display("FAIL scan_wrap cycle %0d: idx=%0d wrap=%b out=%b required idx=%0d wrap=%b", i, idx, wrap, out, ei, (i == 8));
         end
      end
   endtask

   task automatic test_mode_change();
      step(0, 0, 0);
      step(1, 1, 3);
      step(1, 1, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      tests_run++;
      if (out !== 8'b0000_0001 || idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL mode_change_direct: out=%b idx=%0d required out=00000001 idx=0", out, idx);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0);
         tests_run++;
         if (idx !== ((i < 4) ? 3'd0 : 3'd1) || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode_change_rescan cycle %0d: idx=%0d wrap=%b required idx=%0d wrap=0", i, idx, wrap, (i < 4) ? 0 : 1);
         end
      end
   endtask

   task automatic test_en_drop();
      step(0, 0, 0);
      step(1, 1, 4);
      step(1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 3'($urandom_range(0, 7)));
         tests_run++;
         if (out !== 8'h00 || idx !== 3'd4 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_drop_idle cycle %0d: out=%h idx=%0d wrap=%b required out=00 idx=4 wrap=0", i, out, idx, wrap);
         end
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 1, (i == 0) ? 3'd1 : 3'd6);
         tests_run++;
         if (idx !== ((i < 4) ? 3'd1 : 3'd2) || out !== exp_out()) begin
            tests_failed++;
            $display("FAIL en_drop_restart cycle %0d: idx=%0d out=%b required idx=%0d out=%b", i, idx, out, (i < 4) ? 1 : 2, exp_out());
         end
      end
   endtask

   task automatic test_async_reset();
      step(0, 0, 0);
      step(1, 1, 7);
      repeat (4) step(1, 1, 0);
      tests_run++;
      if (idx !== 3'd0 || wrap !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_wrap: idx=%0d wrap=%b required idx=0 wrap=1", idx, wrap);
      end
      step(1, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++;
      if (out !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: out=%h idx=%0d wrap=%b required out=00 idx=0 wrap=0", out, idx, wrap);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 3);
      tests_run++;
      if (out !== 8'b0000_1000 || idx !== 3'd3) begin
         tests_failed++;
         $display("FAIL first_edge_after_reset: out=%b idx=%0d required out=00001000 idx=3", out, idx);
      end
   endtask

   task automatic test_active_low();
      logic [3:0] e_out [4];
      logic [1:0] e_idx [4];
      logic       e_wrap [4];
      e_out  = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
      e_idx  = '{2'd3, 2'd0, 2'd1, 2'd2};
      e_wrap = '{1'b0, 1'b1, 1'b0, 1'b0};
      en2 = 1'b0;
      step(0, 0, 0);
      tests_run++;
      if (out2 !== 4'b1111) begin
         tests_failed++;
         $display("FAIL active_low_idle: out=%b required out=1111", out2);
      end
      en2 = 1'b1; mode2 = 1'b1; sel2 = 2'd3;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         sel2 = 2'($urandom_range(0, 3));
         tests_run++;
         if (out2 !== e_out[i] || idx2 !== e_idx[i] || wrap2 !== e_wrap[i]) begin
            tests_failed++;
            $display("FAIL active_low_scan cycle %0d: out=%b idx=%0d wrap=%b required out=%b idx=%0d wrap=%b", i, out2, idx2, wrap2, e_out[i], e_idx[i], e_wrap[i]);
         end
      end
      en2 = 1'b0;
   endtask

   task automatic test_random();
      logic e, m;
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 15) != 0);
         m = ($urandom_range(0, 7) != 0);
         step(e, m, 3'($urandom_range(0, 7)));
         tests_run++;
         if (out !== exp_out()) begin
            tests_failed++;
            $display("FAIL random_out cycle %0d: out=%b required %b", i, out, exp_out());
         end
         tests_run++;
         if (idx !== 3'(m_idx)) begin
            tests_failed++;
            $display("FAIL random_idx cycle %0d: idx=%0d required %0d", i, idx, m_idx);
         end
         tests_run++;
         if (wrap !== m_wrap) begin
            tests_failed++;
            $display("FAIL random_wrap cycle %0d: wrap=%b required %b", i, wrap, m_wrap);
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan_wrap();
      test_mode_change();
      test_en_drop();
      test_async_reset();
      test_active_low();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 3, select width; output width is 2**SEL_W.
REQ-002 Parameter DWELL, default 4, clock cycles each output stays active in scan mode; legal range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 0; 1 inverts every bit of out.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  block enable; 0 forces all outputs inactive.
REQ-007 mode  input  1  0 = direct decode of sel, 1 = auto-scan.
REQ-008 sel  input  SEL_W  direct-mode index; scan start index on scan entry.
REQ-009 out  output  2**SEL_W  registered one-hot (one-cold if ACTIVE_LOW) decode of idx.
REQ-010 idx  output  SEL_W  registered index currently driven on out.
REQ-011 wrap  output  1  one-cycle pulse when scan index wraps from 2**SEL_W-1 to 0.

Function
REQ-012 The FSM SHALL have states IDLE, DIRECT and SCAN, updated on each rising clk edge.
REQ-013 Any state with en=0 SHALL go to IDLE; IDLE holds idx, clears the dwell counter, and drives out inactive (all 0, or all 1 if ACTIVE_LOW).
REQ-014 With en=1 and mode=0, the next state SHALL be DIRECT, with idx<=sel every cycle; out reflects sel one cycle after sampling.
REQ-015 With en=1 and mode=1 from IDLE or DIRECT, the next state SHALL be SCAN, with idx<=sel (start index) and the dwell counter at 0.
REQ-016 In SCAN, the dwell counter SHALL count 0..DWELL-1; on the cycle it equals DWELL-1, it returns to 0 and idx increments by 1.
REQ-017 idx increment SHALL be modulo 2**SEL_W; the edge taking idx from 2**SEL_W-1 to 0 SHALL set wrap=1 for exactly one cycle.
REQ-018 wrap SHALL be 0 in every other cycle, including in IDLE and DIRECT and on scan entry at index 0.
REQ-019 In SCAN, sel SHALL be ignored after the entry cycle.
REQ-020 With DWELL=1, idx SHALL advance every cycle in SCAN.
REQ-021 out SHALL be the one-hot decode of idx, bit idx set, in DIRECT and SCAN, inverted bitwise when ACTIVE_LOW=1; exactly one bit is active.
REQ-022 A mode change 1->0 mid-dwell SHALL leave SCAN on the next edge, abandon the dwell count, and load sel.
REQ-023 en deasserted mid-scan then reasserted with mode=1 SHALL restart the scan from sel, not resume.
REQ-024 The dwell counter SHALL be ceil(log2(DWELL+1)) bits wide with no overflow for any legal DWELL.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, idx=0, dwell counter=0 and wrap=0, with out inactive, regardless of clk.
REQ-026 The first rising edge after rst_n release SHALL evaluate en/mode normally; no extra latency cycles.
REQ-027 Reset asserted mid-scan SHALL discard all scan progress.

Verification (SEL_W=3, DWELL=4, ACTIVE_LOW=0 unless stated)
REQ-028 Reset then en=1, mode=0, sel=5 -> one edge later out=8'b0010_0000 and idx=5; sel=2 next cycle -> out=8'b0000_0100 one edge later.
REQ-029 en=1, mode=1, sel=6 -> idx=6 for 4 cycles, then idx=7 for 4 cycles, then idx=0 with wrap=1 in that single cycle only, then idx=1 after 4 more cycles.
REQ-030 SCAN at idx=3, dwell count 2: mode->0 with sel=0 -> next edge out=8'b0000_0001; mode->1 again -> scan restarts at idx=0 with a full 4-cycle dwell.
REQ-031 SCAN at idx=4: en=0 for 3 cycles -> out=8'h00 with idx held at 4; en=1, mode=1, sel=1 -> scan restarts at idx=1.
REQ-032 rst_n pulsed low between clock edges during SCAN -> out=8'h00, idx=0 and wrap=0 immediately, with no clk edge required.
REQ-033 ACTIVE_LOW=1, DWELL=1, SEL_W=2, scan from sel=3 -> out sequence 4'b0111, 4'b1110 (wrap=1), 4'b1101, 4'b1011 on consecutive cycles.
